// File: rtl/riscv_pkg.sv
// Shared types for the data-memory port arbiter.
// State encoding and port count used by the arbiter and its picker.
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WRITE,
    ARB_READ,
    ARB_RESP
  } arb_state_t;

  localparam int ARB_NUM_PORTS = 2;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Two-port round-robin picker.
// On contention the port that did not win last time is chosen.
module riscv_rr_arbiter
  import riscv_pkg::*;
(
  input  logic [ARB_NUM_PORTS-1:0] req,
  input  logic                     last_gnt,
  output logic [ARB_NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      (req == 2'b11): gnt = last_gnt ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = '0;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_port_arbiter.sv
// Shares one data-memory port between the memory stage (port 0)
// and the DMA engine (port 1), one transaction in flight.
module riscv_dmem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              i_req_valid,
  input  logic [1:0]              i_req_write,
  input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
  input  logic [2*STRB_WIDTH-1:0] i_req_strb,
  output logic [1:0]              o_req_ready,
  output logic [1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic                    o_busy,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_wr_valid,
  input  logic                    i_mem_wr_ready,
  output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
  output logic [STRB_WIDTH-1:0]   o_mem_wr_strb,
  output logic                    o_mem_rd_ready,
  input  logic                    i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rd_data
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t            state;
  logic                  last_gnt;
  logic                  gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CW-1:0]         cnt;

  logic [1:0]            gnt_oh;
  logic                  gnt_idx;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic                  expire;
  logic                  in_mem;

  riscv_rr_arbiter u_rr (
    .req      (i_req_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt_oh)
  );

  assign gnt_idx = gnt_oh[1];

  always_comb begin
    sel_write = i_req_write[gnt_idx];
    sel_addr  = gnt_idx ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                        : i_req_addr[ADDR_WIDTH-1:0];
    sel_data  = gnt_idx ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                        : i_req_wdata[DATA_WIDTH-1:0];
    sel_strb  = gnt_idx ? i_req_strb[2*STRB_WIDTH-1:STRB_WIDTH]
                        : i_req_strb[STRB_WIDTH-1:0];
  end

  // TIMEOUT == 0 disables the watchdog entirely
  assign expire = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|gnt_oh) begin
            gnt_q    <= gnt_idx;
            last_gnt <= gnt_idx;
            addr_q   <= sel_addr;
            data_q   <= sel_data;
            strb_q   <= sel_strb;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
            state    <= sel_write ? ARB_WRITE : ARB_READ;
          end
        end
        ARB_WRITE: begin
          if (i_mem_wr_ready) begin
            err_q <= 1'b0;
            state <= ARB_RESP;
          end else if (expire) begin
            err_q <= 1'b1;
            state <= ARB_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_READ: begin
          if (i_mem_rd_valid) begin
            rdata_q <= i_mem_rd_data;
            err_q   <= 1'b0;
            state   <= ARB_RESP;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ARB_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign in_mem = (state == ARB_WRITE) || (state == ARB_READ);

  assign o_req_ready    = (state == ARB_IDLE && !reset) ? gnt_oh : 2'b00;
  assign o_busy         = (state != ARB_IDLE);
  assign o_rsp_valid    = (state != ARB_RESP) ? 2'b00 :
                          (gnt_q ? 2'b10 : 2'b01);
  assign o_rsp_rdata    = (state == ARB_RESP) ? rdata_q : '0;
  assign o_rsp_err      = (state == ARB_RESP) && err_q;
  assign o_mem_addr     = in_mem ? addr_q : '0;
  assign o_mem_wr_valid = (state == ARB_WRITE);
  assign o_mem_wr_data  = (state == ARB_WRITE) ? data_q : '0;
  assign o_mem_wr_strb  = (state == ARB_WRITE) ? strb_q : '0;
  assign o_mem_rd_ready = (state == ARB_READ);

endmodule
